// File: rtl/e_mdu_ctrl_pkg.sv
// Shared MDU op codes and result type for the E-stage multiply/divide unit.
package e_mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_long_op(logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_arith.sv
// Combinational 64-bit {HI,LO} result for mult/multu/div/divu; other ops and
// divide-by-zero hand back the current HI/LO so a commit leaves them unchanged.
module e_mdu_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output mdu_res_t    res
);

    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic        neg_a, neg_b;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes so -2^31 / -1 wraps instead of overflowing.
    assign neg_a = a[31];
    assign neg_b = b[31];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;
    assign q_mag = mag_a / mag_b;
    assign r_mag = mag_a % mag_b;
    assign q_s   = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign r_s   = neg_a ? -r_mag : r_mag;
    assign q_u   = a / b;
    assign r_u   = a % b;

    always_comb begin
        res = '{hi: hi, lo: lo};
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   if (b != 32'd0) res = '{hi: r_s, lo: q_s};
            MDU_DIVU:  if (b != 32'd0) res = '{hi: r_u, lo: q_u};
            default:   res = '{hi: hi, lo: lo};
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU sequencer: owns HI/LO, emulates fixed mult/div latency with a
// down-counter and exports E_busy for the D-stage hazard unit.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi, lo;
    mdu_res_t         pend, res;
    logic             idle;

    assign idle = (cnt == '0);

    e_mdu_arith u_arith (
        .op  (E_MDUOp),
        .a   (E_A),
        .b   (E_B),
        .hi  (hi),
        .lo  (lo),
        .res (res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            pend <= '0;
        end else if (idle) begin
            if (E_start && is_long_op(E_MDUOp)) begin
                pend <= res;
                cnt  <= is_div_op(E_MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (E_MDUOp == MDU_MTHI) begin
                hi <= E_A;
            end else if (E_MDUOp == MDU_MTLO) begin
                lo <= E_A;
            end
        end else begin
            // Result becomes architecturally visible on the edge that retires cnt==1.
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                hi <= pend.hi;
                lo <= pend.lo;
            end
        end
    end

    assign E_busy = E_start | ~idle;
    assign E_HI   = hi;
    assign E_LO   = lo;

    always_comb begin
        E_MDUOut = 32'd0;
        if (E_MDUOp == MDU_MFHI)      E_MDUOut = hi;
        else if (E_MDUOp == MDU_MFLO) E_MDUOut = lo;
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed latency/arithmetic cases plus a
// randomized run against a cycle-count based reference model.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [3:0]  E_MDUOp;
    logic [31:0] E_A, E_B;
    logic        E_busy;
    logic [31:0] E_HI, E_LO, E_MDUOut;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural HI/LO plus the edge number of the pending commit.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          edges = 0;
    int          m_commit = 0;

    e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_start(E_start), .E_MDUOp(E_MDUOp),
        .E_A(E_A), .E_B(E_B), .E_busy(E_busy), .E_HI(E_HI), .E_LO(E_LO),
        .E_MDUOut(E_MDUOut)
    );

    always #5 clk = ~clk;

    function automatic bit m_long(logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd3, 4'd4};
    endfunction

    function automatic logic [63:0] ref_res(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                            logic [31:0] hi, logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return 64'(ua * ub);
            4'd3: begin
                if (b == 0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return {hi, lo};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {hi, lo};
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Advance one clock edge, updating the model from the inputs seen before it.
    task automatic step();
        if (E_start && !reset) begin
            n_cmp++;
            if (m_commit > edges) begin
                n_bad++;
                $display("FAIL start_while_busy: E_start=1 at edge %0d, required no start before edge %0d", edges + 1, m_commit);
            end
        end
        if (reset) begin
            m_hi = 0; m_lo = 0; m_commit = 0;
        end else if (m_commit > edges) begin
            if (edges + 1 == m_commit) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (E_start && m_long(E_MDUOp)) begin
            {p_hi, p_lo} = ref_res(E_MDUOp, E_A, E_B, m_hi, m_lo);
            m_commit = edges + 1 + ((E_MDUOp inside {4'd3, 4'd4}) ? DC : MC);
        end else if (E_MDUOp == 4'd5) begin
            m_hi = E_A;
        end else if (E_MDUOp == 4'd6) begin
            m_lo = E_A;
        end
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic idle_inputs();
        E_start = 0; E_MDUOp = MDU_NONE; E_A = 0; E_B = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        E_start = 0; E_MDUOp = MDU_MTHI; E_A = h; step();
        E_MDUOp = MDU_MTLO; E_A = l; step();
        idle_inputs(); #1;
    endtask

    // Issue one long op and wait for completion; hi_pre/lo_pre hold the last pre-commit values.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int busy_cyc, output logic [31:0] hi_pre, output logic [31:0] lo_pre);
        busy_cyc = 0;
        hi_pre = E_HI; lo_pre = E_LO;
        E_start = 1; E_MDUOp = op; E_A = a; E_B = b; #1;
        if (E_busy) busy_cyc++;
        step();
        idle_inputs(); #1;
        for (int k = 0; k < 30 && E_busy; k++) begin
            hi_pre = E_HI; lo_pre = E_LO;
            busy_cyc++;
            step();
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (E_HI !== 32'h0 || E_LO !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_hilo: HI=%h LO=%h required 0/0", E_HI, E_LO);
        end
        n_cmp++;
        if (E_busy !== 1'b0 || E_MDUOut !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_busy: busy=%b out=%h required 0/0", E_busy, E_MDUOut);
        end
        E_start = 1; #1;
        n_cmp++;
        if (E_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_comb_busy: busy=%b required 1", E_busy);
        end
        E_start = 0; #1;
    endtask

    task automatic test_mult();
        int bc;
        logic [31:0] hp, lp;
        run_long(MDU_MULT, 32'hFFFF_FFFF, 32'd2, bc, hp, lp);
        n_cmp++;
        if (bc !== MC + 1) begin n_bad++; $display("FAIL mult_busy: %0d cycles required %0d", bc, MC + 1); end
        n_cmp++;
        if (E_HI !== 32'hFFFF_FFFF || E_LO !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL mult_result: HI=%h LO=%h required ffffffff/fffffffe", E_HI, E_LO);
        end
        n_cmp++;
        if (hp !== 32'h0 || lp !== 32'h0) begin
            n_bad++; $display("FAIL mult_early: pre-commit HI=%h LO=%h required 0/0", hp, lp);
        end
        run_long(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, bc, hp, lp);
        n_cmp++;
        if (E_HI !== 32'h1 || E_LO !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL multu_result: HI=%h LO=%h required 00000001/fffffffe", E_HI, E_LO);
        end
        n_cmp++;
        if (hp !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL multu_early: pre-commit HI=%h required ffffffff", hp);
        end
    endtask

    task automatic test_div();
        int bc;
        logic [31:0] hp, lp;
        run_long(MDU_DIV, 32'hFFFF_FFF9, 32'd2, bc, hp, lp);
        n_cmp++;
        if (bc !== DC + 1) begin n_bad++; $display("FAIL div_busy: %0d cycles required %0d", bc, DC + 1); end
        n_cmp++;
        if (E_LO !== 32'hFFFF_FFFD || E_HI !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL div_neg: HI=%h LO=%h required ffffffff/fffffffd", E_HI, E_LO);
        end
        run_long(MDU_DIV, 32'd7, 32'hFFFF_FFFE, bc, hp, lp);
        n_cmp++;
        if (E_LO !== 32'hFFFF_FFFD || E_HI !== 32'h1) begin
            n_bad++; $display("FAIL div_negdivisor: HI=%h LO=%h required 00000001/fffffffd", E_HI, E_LO);
        end
        run_long(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, hp, lp);
        n_cmp++;
        if (E_LO !== 32'h8000_0000 || E_HI !== 32'h0) begin
            n_bad++; $display("FAIL div_overflow: HI=%h LO=%h required 00000000/80000000", E_HI, E_LO);
        end
        write_hilo(32'h11, 32'h22);
        run_long(MDU_DIVU, 32'd1234, 32'd0, bc, hp, lp);
        n_cmp++;
        if (bc !== DC + 1) begin n_bad++; $display("FAIL divzero_busy: %0d cycles required %0d", bc, DC + 1); end
        n_cmp++;
        if (E_HI !== 32'h11 || E_LO !== 32'h22) begin
            n_bad++; $display("FAIL divzero_hilo: HI=%h LO=%h required 00000011/00000022", E_HI, E_LO);
        end
    endtask

    task automatic test_reset_mid();
        write_hilo(32'h5, 32'h6);
        E_start = 1; E_MDUOp = MDU_DIV; E_A = 32'd100; E_B = 32'd7;
        step();
        idle_inputs();
        step(); step(); step();
        reset = 1; step(); reset = 0; #1;
        n_cmp++;
        if (E_busy !== 1'b0 || E_HI !== 32'h0 || E_LO !== 32'h0) begin
            n_bad++; $display("FAIL reset_mid: busy=%b HI=%h LO=%h required 0/0/0", E_busy, E_HI, E_LO);
        end
        for (int k = 0; k < DC + 2; k++) step();
        n_cmp++;
        if (E_HI !== 32'h0 || E_LO !== 32'h0) begin
            n_bad++; $display("FAIL reset_mid_late: HI=%h LO=%h required 0/0", E_HI, E_LO);
        end
    endtask

    task automatic test_mt_mf();
        int bc;
        logic [31:0] hp, lp;
        E_MDUOp = MDU_MTHI; E_A = 32'hABCD; #1;
        n_cmp++;
        if (E_busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: busy=%b required 0", E_busy); end
        step();
        n_cmp++;
        if (E_HI !== 32'hABCD) begin n_bad++; $display("FAIL mthi: HI=%h required 0000abcd", E_HI); end
        E_MDUOp = MDU_MFHI; #1;
        n_cmp++;
        if (E_MDUOut !== 32'hABCD) begin n_bad++; $display("FAIL mfhi: out=%h required 0000abcd", E_MDUOut); end
        E_MDUOp = MDU_MFLO; #1;
        n_cmp++;
        if (E_MDUOut !== 32'h0) begin n_bad++; $display("FAIL mflo: out=%h required 00000000", E_MDUOut); end
        E_start = 1; E_MDUOp = MDU_MULTU; E_A = 32'd3; E_B = 32'd4; step();
        E_start = 0; E_MDUOp = MDU_MTLO; E_A = 32'h5555; step();
        idle_inputs(); #1;
        n_cmp++;
        if (E_LO !== 32'h0) begin n_bad++; $display("FAIL mtlo_during_run: LO=%h required 00000000", E_LO); end
        for (int k = 0; k < MC; k++) step();
        n_cmp++;
        if (E_LO !== 32'd12 || E_HI !== 32'h0) begin
            n_bad++; $display("FAIL run_commit: HI=%h LO=%h required 0/0000000c", E_HI, E_LO);
        end
        // Back-to-back: next long op accepted right after the commit cycle.
        run_long(MDU_MULT, 32'hFFFF_FFFD, 32'd5, bc, hp, lp);
        n_cmp++;
        if (bc !== MC + 1 || E_LO !== 32'hFFFF_FFF1 || E_HI !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL back_to_back: busy=%0d HI=%h LO=%h required %0d/ffffffff/fffffff1", bc, E_HI, E_LO, MC + 1);
        end
        E_start = 1; E_MDUOp = 4'd12; E_A = 32'h77; step(); idle_inputs(); #1;
        n_cmp++;
        if (E_busy !== 1'b0 || E_LO !== 32'hFFFF_FFF1 || E_HI !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL unknown_op: busy=%b HI=%h LO=%h required 0/ffffffff/fffffff1", E_busy, E_HI, E_LO);
        end
    endtask

    task automatic test_random();
        int sel;
        logic [31:0] exp_out;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = (m_commit > edges) ? $urandom_range(5, 9) : $urandom_range(0, 9);
            E_A = rnd32(); E_B = rnd32();
            E_start = (sel <= 4);
            case (sel)
                0: E_MDUOp = MDU_MULT;
                1: E_MDUOp = MDU_MULTU;
                2: E_MDUOp = MDU_DIV;
                3: E_MDUOp = MDU_DIVU;
                4: E_MDUOp = 4'($urandom_range(9, 15));
                5: E_MDUOp = MDU_MTHI;
                6: E_MDUOp = MDU_MTLO;
                7: E_MDUOp = MDU_MFHI;
                8: E_MDUOp = MDU_MFLO;
                default: E_MDUOp = MDU_NONE;
            endcase
            #1;
            exp_out = (E_MDUOp == 4'd7) ? m_hi : (E_MDUOp == 4'd8) ? m_lo : 32'h0;
            n_cmp++;
            if (E_busy !== (E_start || (m_commit > edges)) || E_MDUOut !== exp_out) begin
                n_bad++;
                $display("FAIL rnd_comb[%0d]: busy=%b out=%h required %b/%h", i, E_busy, E_MDUOut,
                         (E_start || (m_commit > edges)), exp_out);
            end
            step();
            n_cmp++;
            if (E_HI !== m_hi || E_LO !== m_lo) begin
                n_bad++;
                $display("FAIL rnd_hilo[%0d]: HI=%h LO=%h required %h/%h", i, E_HI, E_LO, m_hi, m_lo);
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_mult();
        test_div();
        test_reset_mid();
        test_mt_mf();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
